// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the block-RAM arbiter.
// Optional feature macro: BRAM_ARB_LOCK_EN (per-requester port lock).
package bram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Requester identity; also the index into the 2-bit req/gnt vectors.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Identity of the requester that is not `id`.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

  // Convert a one-hot grant into the winning requester id (A when idle).
  function automatic req_id_t gnt_to_id(input logic [1:0] gnt);
    return gnt[1] ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/bram_arb_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// With BRAM_ARB_LOCK_EN defined, a winner that asserts lock reserves the
// port until it drops lock, even across idle cycles.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] gnt
);

  req_id_t last_q, last_d;

`ifdef BRAM_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic owner_lock;
  logic win_lock;

  // Lock bit of the current owner (the last granted requester).
  assign owner_lock = (last_q == REQ_A) ? lock[0] : lock[1];
  assign win_lock   = gnt[1] ? lock[1] : lock[0];
`endif

  // Grant decision; forced idle while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
`ifdef BRAM_ARB_LOCK_EN
      // A reserved port only serves its owner.
      if (locked_q) begin
        gnt = (last_q == REQ_A) ? {1'b0, req[0]} : {req[1], 1'b0};
      end
`endif
    end
  end

  // Next last-grant: only moves on an actual grant.
  always_comb begin
    last_d = last_q;
    if (gnt != 2'b00) begin
      last_d = gnt_to_id(gnt);
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  // Next lock state: set/cleared by the winner's lock on a grant, otherwise
  // released only when the idle owner drops its lock.
  always_comb begin
    locked_d = locked_q;
    if (gnt != 2'b00) begin
      locked_d = win_lock;
    end else if (locked_q && !owner_lock) begin
      locked_d = 1'b0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end
`endif

  // Last-grant register; resets to B so A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bram_arb.sv
// Two-requester arbiter in front of a simple dual-port block RAM with a
// 1-cycle registered read. Read and write ports are arbitrated independently.
// Optional feature macro: BRAM_ARB_LOCK_EN adds a_lock/b_lock port reservation.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic              a_lock,
  input  logic              b_lock,
`endif
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  logic [1:0] rd_req, wr_req;
  logic [1:0] rd_gnt, wr_gnt;
  logic       rd_pend_q;
  req_id_t    rd_owner_q;

  // Split each request onto the port class selected by its we bit.
  assign rd_req = {b_req & ~b_we, a_req & ~a_we};
  assign wr_req = {b_req &  b_we, a_req &  a_we};

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (rd_req),
`ifdef BRAM_ARB_LOCK_EN
    .lock ({b_lock, a_lock}),
`endif
    .gnt  (rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req),
`ifdef BRAM_ARB_LOCK_EN
    .lock ({b_lock, a_lock}),
`endif
    .gnt  (wr_gnt)
  );

  // A requester holds only one request, so at most one port grants it.
  assign a_gnt = rd_gnt[0] | wr_gnt[0];
  assign b_gnt = rd_gnt[1] | wr_gnt[1];

  // Read-port RAM drive; zero address when idle.
  always_comb begin
    mem_rd_en   = |rd_gnt;
    mem_rd_addr = '0;
    if (rd_gnt[0]) begin
      mem_rd_addr = a_addr;
    end else if (rd_gnt[1]) begin
      mem_rd_addr = b_addr;
    end
  end

  // Write-port RAM drive; zero address/data when idle.
  always_comb begin
    mem_wr_en   = |wr_gnt;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (wr_gnt[0]) begin
      mem_wr_addr = a_addr;
      mem_wr_data = a_wdata;
    end else if (wr_gnt[1]) begin
      mem_wr_addr = b_addr;
      mem_wr_data = b_wdata;
    end
  end

  // Track who owns the read data returning next cycle; reset drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_A;
    end else begin
      rd_pend_q <= |rd_gnt;
      if (|rd_gnt) begin
        rd_owner_q <= gnt_to_id(rd_gnt);
      end
    end
  end

  assign a_rvalid = rd_pend_q && (rd_owner_q == REQ_A);
  assign b_rvalid = rd_pend_q && (rd_owner_q == other_req(REQ_A));

  // RAM output is registered already; pass it straight through.
  assign a_rdata = mem_rd_data;
  assign b_rdata = mem_rd_data;

endmodule

// File: doc/bram_arb.md
Name: bram_arb

Overview:
- Two-requester arbiter in front of the 1024x8 simple dual-port block RAM: one read port, one write port, 1-cycle registered read.
- Read and write ports are arbitrated independently, so one requester may read while the other writes in the same cycle.
- Each port uses a round-robin policy.
- Sits between the datapath clients (A, B) and the RAM instance and owns all RAM control signals.

Parameters:
- ADDR_W, 10, RAM address width (depth 2**ADDR_W)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  A requests an access this cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A access accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid (registered)
- a_rdata  out  DATA_W  A read data, meaningful only when a_rvalid=1
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- mem_rd_en  out  1  to RAM rd_en
- mem_rd_addr  out  ADDR_W  to RAM rd_addr
- mem_wr_en  out  1  to RAM wr_en
- mem_wr_addr  out  ADDR_W  to RAM wr_addr
- mem_wr_data  out  DATA_W  to RAM wr_data
- mem_rd_data  in  DATA_W  from RAM rd_data

Behaviour:
- Port classes: a request with we=0 competes for the read port; we=1 competes for the write port.
- Handshake: valid/ready. A request is accepted in the cycle req=1 and gnt=1. The requester holds req, we, addr and wdata stable until granted. gnt never asserts without req.
- Per-port state: 1-bit last_rd and last_wr, holding the last requester granted on that port.
  - Reset value of each = B, so A wins the first contention.
  - Updated only on a grant on that port.
- Grant rule per port:
  - Single contender: granted.
  - Both contend: grant the one != last.
  - Neither: port idle.
- RAM drive is combinational from the grant:
  - mem_rd_en = read granted; mem_rd_addr = winner addr.
  - mem_wr_en / mem_wr_addr / mem_wr_data likewise.
  - Idle port: en=0, addr/data=0.
- Read return:
  - Registered rd_owner and rd_pend; x_rvalid=1 exactly one cycle after x's read grant.
  - x_rdata = mem_rd_data, passed through unregistered.
  - Reads sustain one per cycle (back-to-back alternating A/B under contention).
- Same-cycle read and write to the same address: the read returns old contents (RAM read-first behaviour); the arbiter does no forwarding.
- Reset, including mid-operation:
  - All gnt, mem_*_en and rvalid = 0 while rst=1.
  - last_* = B; any pending read return is dropped (no rvalid after reset).
  - Requests outstanding at reset must be re-presented.
- Starvation bound: a requester held active on a port is granted within 2 cycles.

Optional Feature:
- Macro BRAM_ARB_LOCK_EN.
- With the macro:
  - Adds inputs a_lock and b_lock (1 bit each).
  - If the current winner of a port has lock=1 when granted, that port is reserved for it in subsequent cycles. The other requester is not granted on that port, even if the owner idles, until the owner deasserts lock.
  - Lock state per port is reset to unlocked by rst.
  - Lock requested by both requesters on different ports is legal.
- Without the macro: the lock ports and state do not exist; pure round-robin.

Decomposition:
- Package bram_arb_pkg:
  - default ADDR_W=10, DATA_W=8
  - requester id type (REQ_A=0, REQ_B=1)
- Sub-module rr_arb2:
  - 2-way round-robin with last-grant register and optional lock
  - instantiated once for the read port, once for the write port
- Top does the we-based request split, RAM mux and read-return tracking.

Test Plan:
- RAM preloaded with addr 12 = 0x42. A reads 12 alone -> a_gnt same cycle, a_rvalid next cycle with a_rdata=0x42, b_rvalid=0.
- A and B both read (A addr 0, B addr 1) continuously for 4 cycles -> grants A,B,A,B; rvalid alternates one cycle later with data 0x00/0x01.
- A writes 0x5A to addr 20 while B reads addr 20 in the same cycle -> both granted; B gets old value. B reads again -> 0x5A.
- Both write (A 0x11 to addr 3, B 0x22 to addr 3) for 2 cycles -> A first, then B; a final read of addr 3 returns 0x22.
- rst asserted the cycle after a read grant -> no rvalid; after release, contention is granted to A first.
- (BRAM_ARB_LOCK_EN) A reads with a_lock=1 for 3 cycles, B reads continuously -> B_gnt=0 until the cycle after a_lock drops, then B is granted.
